// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU load/store, debug hold/readback and data-memory signals around dmem_arbiter.
// slave is the arbiter's view; master is the view of the core, board port and memory around it.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic                hld;
  logic [ADDR_W-1:0]   addr;
  logic                sel;
  logic [DATA_W/2-1:0] out;
  logic                out_valid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, hld, addr, sel, mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall, out, out_valid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, hld, addr, sel, mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall, out, out_valid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store unit and the debug hold/readback port.
// Optional macro DMEM_ARB_ADDR_TRACK_EN: re-read the memory when the debug address changes during a hold.
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int         HALF_W = DATA_W / 2;
  localparam logic [1:0] LAT    = 2'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    DBG_ACC  = 2'd2,
    DBG_HOLD = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        lat_cnt;
  logic              acc_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_word;

  function automatic logic [HALF_W-1:0] half_sel(input logic [DATA_W-1:0] word, input logic hi);
    return hi ? word[DATA_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

  // Arbitration FSM; every memory-side and client-side output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= 2'd0;
      acc_we        <= 1'b0;
      dbg_addr      <= '0;
      dbg_word      <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.cpu_stall <= 1'b0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en  <= 1'b0;
      bus.cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Debug wins a tie; the CPU request simply stays pending.
          if (bus.hld) begin
            state         <= DBG_ACC;
            bus.cpu_stall <= 1'b1;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.addr;
            dbg_addr      <= bus.addr;
            lat_cnt       <= 2'd0;
          end else if (bus.cpu_req) begin
            state         <= CPU_ACC;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.cpu_we;
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_wdata <= bus.cpu_wdata;
            acc_we        <= bus.cpu_we;
            lat_cnt       <= 2'd0;
          end
        end
        CPU_ACC: begin
          if (acc_we || (lat_cnt == LAT)) begin
            bus.cpu_ack <= 1'b1;
            if (!acc_we) begin
              bus.cpu_rdata <= bus.mem_rdata;
            end
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        DBG_ACC: begin
          if (lat_cnt == LAT) begin
            if (bus.hld) begin
              dbg_word      <= bus.mem_rdata;
              bus.out       <= half_sel(bus.mem_rdata, bus.sel);
              bus.out_valid <= 1'b1;
              state         <= DBG_HOLD;
            end else begin
              bus.cpu_stall <= 1'b0;
              state         <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        DBG_HOLD: begin
          if (!bus.hld) begin
            bus.cpu_stall <= 1'b0;
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
`ifdef DMEM_ARB_ADDR_TRACK_EN
          else if (bus.addr != dbg_addr) begin
            bus.out_valid <= 1'b0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.addr;
            dbg_addr      <= bus.addr;
            lat_cnt       <= 2'd0;
            state         <= DBG_ACC;
          end
`endif
          else begin
            // Halfword select is served from the stored word, no memory traffic.
            bus.out <= half_sel(dbg_word, bus.sel);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural single-port memory (RD_LAT = 1).
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int en_cnt  = 0;
  int ack_cnt = 0;
  int last_en = -100;
  int last_gap = 0;

  logic [DATA_W-1:0] mem_model [0:63];

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model with one-cycle read latency, plus access/ack monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en === 1'b1) begin
      en_cnt   <= en_cnt + 1;
      last_gap <= cyc - last_en;
      last_en  <= cyc;
      if (bus.mem_we === 1'b1) begin
        mem_model[bus.mem_addr[5:0]] <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= mem_model[bus.mem_addr[5:0]];
      end
    end
    if (bus.cpu_ack === 1'b1) begin
      ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n, output logic [31:0] rd);
    bit done = 1'b0;
    n  = 0;
    rd = '0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (bus.cpu_ack === 1'b1) begin
        rd   = bus.cpu_rdata;
        done = 1'b1;
      end
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          output logic [31:0] rd, output int lat);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    wait_ack(lat, rd);
    bus.cpu_req   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_hold;
    int          lat;
    int          a0;
    int          e0;

    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.hld       = 1'b0;
    bus.addr      = '0;
    bus.sel       = 1'b0;
    tick();
    tick();
    check("rst_cpu_ack",   32'(bus.cpu_ack),   32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata,      32'h0);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
    check("rst_out",       32'(bus.out),       32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_mem_en",    32'(bus.mem_en),    32'h0);
    check("rst_mem_we",    32'(bus.mem_we),    32'h0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    check("rst_mem_wdata", bus.mem_wdata,      32'h0);
    rst = 1'b0;
    tick();

    // Store then load word 5.
    cpu_xfer(1'b1, 14'd5, 32'hDEADBEEF, rd, lat);
    check("store_lat", 32'(lat), 32'd2);
    cpu_xfer(1'b0, 14'd5, 32'h0, rd, lat);
    check("load_lat",  32'(lat), 32'd3);
    check("load_data", rd, 32'hDEADBEEF);
    cpu_xfer(1'b1, 14'd1, 32'h1234ABCD, rd, lat);
    cpu_xfer(1'b1, 14'd2, 32'h00000007, rd, lat);

    // Hold readback of word 1.
    bus.hld  = 1'b1;
    bus.addr = 14'd1;
    bus.sel  = 1'b0;
    tick();
    check("hold_stall",   32'(bus.cpu_stall), 32'h1);
    check("hold_mem_en",  32'(bus.mem_en),    32'h1);
    check("hold_mem_we",  32'(bus.mem_we),    32'h0);
    tick();
    check("hold_early_valid", 32'(bus.out_valid), 32'h0);
    tick();
    check("hold_valid", 32'(bus.out_valid), 32'h1);
    check("hold_out_lo", 32'(bus.out), 32'h0000ABCD);
    e0 = en_cnt;
    bus.sel = 1'b1;
    tick();
    check("hold_out_hi", 32'(bus.out), 32'h00001234);
    check("sel_no_access", 32'(en_cnt), 32'(e0));
    bus.sel = 1'b0;
    tick();
    check("hold_out_lo2", 32'(bus.out), 32'h0000ABCD);

    // Address change while holding.
    bus.addr = 14'd2;
    tick();
`ifdef DMEM_ARB_ADDR_TRACK_EN
    check("track_drop_valid", 32'(bus.out_valid), 32'h0);
    tick();
    tick();
    check("track_valid", 32'(bus.out_valid), 32'h1);
    check("track_out",   32'(bus.out),       32'h00000007);
    exp_hold = 32'h00000007;
`else
    check("notrack_valid", 32'(bus.out_valid), 32'h1);
    tick();
    tick();
    check("notrack_out", 32'(bus.out), 32'h0000ABCD);
    exp_hold = 32'h0000ABCD;
`endif

    // Release.
    bus.hld = 1'b0;
    tick();
    check("release_stall", 32'(bus.cpu_stall), 32'h0);
    check("release_valid", 32'(bus.out_valid), 32'h0);
    check("release_out",   32'(bus.out),       exp_hold);

    // Collision: load of word 2 and hold on word 1 in the same cycle.
    a0 = ack_cnt;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 14'd2;
    bus.hld      = 1'b1;
    bus.addr     = 14'd1;
    bus.sel      = 1'b1;
    tick();
    check("coll_stall",    32'(bus.cpu_stall), 32'h1);
    check("coll_mem_addr", 32'(bus.mem_addr),  32'd1);
    tick();
    tick();
    check("coll_valid", 32'(bus.out_valid), 32'h1);
    check("coll_out",   32'(bus.out),       32'h00001234);
    bus.hld = 1'b0;
    tick();
    check("coll_unstall", 32'(bus.cpu_stall), 32'h0);
    check("coll_no_ack",  32'(ack_cnt),       32'(a0));
    wait_ack(lat, rd);
    bus.cpu_req = 1'b0;
    check("coll_load_data", rd, 32'h00000007);

    // Deferred hold: hold rises just after a load issues.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 14'd1;
    tick();
    check("defer_mem_en", 32'(bus.mem_en), 32'h1);
    bus.hld  = 1'b1;
    bus.addr = 14'd1;
    bus.sel  = 1'b1;
    wait_ack(lat, rd);
    bus.cpu_req = 1'b0;
    check("defer_ack_lat",   32'(lat), 32'd2);
    check("defer_load_data", rd, 32'h1234ABCD);
    check("defer_stall_ack", 32'(bus.cpu_stall), 32'h0);
    tick();
    check("defer_stall", 32'(bus.cpu_stall), 32'h1);
    tick();
    check("defer_gap", 32'(last_gap), 32'(RD_LAT + 2));
    tick();
    check("defer_out", 32'(bus.out), 32'h00001234);
    bus.hld = 1'b0;
    tick();

    // Reset during an outstanding debug read.
    bus.hld  = 1'b1;
    bus.addr = 14'd2;
    bus.sel  = 1'b0;
    tick();
    check("midrst_issue", 32'(bus.mem_en), 32'h1);
    rst     = 1'b1;
    bus.hld = 1'b0;
    tick();
    check("midrst_stall", 32'(bus.cpu_stall), 32'h0);
    check("midrst_out",   32'(bus.out),       32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    check("midrst_no_update", 32'(bus.out), 32'h0);
    check("midrst_valid2",    32'(bus.out_valid), 32'h0);
    cpu_xfer(1'b0, 14'd2, 32'h0, rd, lat);
    check("postrst_lat",  32'(lat), 32'd3);
    check("postrst_data", rd, 32'h00000007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
